laser_seq_ctrl: RTL and testbench
=================================

LASER_SEQ_CTRL -- requirements
Module: laser_seq_ctrl

Interface
REQ-001 Parameter AW, default 4: RAM address width; depth DEPTH = 2^AW words.
REQ-002 Parameter PERIOD, default 4: clocks per playback sample, legal range 2..255.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rec  input  1  start-record pulse.
REQ-006 play  input  1  start-playback pulse.
REQ-007 stop  input  1  abort current record/playback.
REQ-008 loop  input  1  playback restarts at address 0 after last word when high.
REQ-009 in  input  8  sample byte to record.
REQ-010 in_valid  input  1  in is valid this cycle.
REQ-011 out  output  8  last played sample, held between samples.
REQ-012 out_valid  output  1  one-cycle pulse when out updates.
REQ-013 busy  output  1  high when state != IDLE.
REQ-014 done  output  1  one-cycle pulse on completion or abort.
REQ-015 len  output  AW+1  number of words recorded, 0..DEPTH.
REQ-016 ram_addr  output  AW  RAM address, registered.
REQ-017 ram_wdata  output  8  RAM write data, registered.
REQ-018 ram_we  output  1  RAM write enable, registered.
REQ-019 ram_rdata  input  8  RAM read data, valid exactly 1 cycle after ram_addr presented with ram_we=0.

Function
REQ-020 States SHALL be IDLE, REC, PLAY; busy = (state != IDLE).
REQ-021 IDLE: rec=1 -> REC, write pointer=0, len=0; rec and play both high -> rec wins.
REQ-022 IDLE: play=1 with len>0 -> PLAY, read pointer=0, sample timer=0; play with len=0 ignored, no done.
REQ-023 rec/play asserted while busy SHALL be ignored.
REQ-024 REC: each cycle with in_valid=1 -> next cycle ram_we=1, ram_addr=wptr, ram_wdata=in; wptr+1; len+1.
REQ-025 REC: ram_we SHALL be 0 in every cycle not following an accepted in_valid.
REQ-026 REC: write making len=DEPTH -> IDLE with done pulse in the cycle ram_we is asserted for that write; further in_valid ignored.
REQ-027 REC: stop=1 -> IDLE, done next cycle, len keeps accepted count; in_valid in the stop cycle SHALL be dropped.
REQ-028 PLAY: timer counts 0..PERIOD-1; at timer=0 a read issues: ram_addr=rptr, ram_we=0, rptr+1.
REQ-029 Read latency: issue in cycle T -> out loaded from ram_rdata at end of T+1; out_valid high in T+2 only.
REQ-030 Read of address len-1 with loop=0 -> no further issues; done and IDLE in the cycle out_valid pulses for that word.
REQ-031 Read of address len-1 with loop=1 -> rptr wraps to 0, reads continue every PERIOD cycles without gap.
REQ-032 PLAY: stop=1 -> IDLE, done next cycle; in-flight read discarded, no out_valid, out retains prior value.
REQ-033 stop in IDLE SHALL have no effect; loop SHALL be sampled at each last-word issue.
REQ-034 Pointers SHALL be AW bits; len SHALL be AW+1 bits and never exceed DEPTH.

Reset
REQ-035 reset=0 SHALL immediately force state IDLE, out=0, out_valid=0, busy=0, done=0, len=0, ram_addr=0, ram_wdata=0, ram_we=0, pointers and timer 0.
REQ-036 Reset mid-REC or mid-PLAY SHALL discard all progress including len; RAM contents untouched by controller.
REQ-037 After reset release, first rising edge SHALL be a normal IDLE cycle.

Verification
REQ-038 Record: rec, then in=8'h11,8'h22,8'h33 with in_valid, stop -> three writes addr 0,1,2 data 11,22,33; done; len=3.
REQ-039 Playback PERIOD=4, loop=0, len=3 -> out_valid every 4 cycles, out=11,22,33, then done, busy=0, no 4th read.
REQ-040 Full: 16 consecutive in_valid (AW=4) -> len=16, done with 16th write, 17th in_valid no write.
REQ-041 Loop: loop=1, len=2 (AA,BB) -> out AA,BB,AA,BB...; stop -> done next cycle, no further out_valid.
REQ-042 Collisions: rec+play together in IDLE -> REC; play with len=0 -> busy stays 0; rec during PLAY ignored.
REQ-043 Async reset mid-PLAY between issue and out_valid -> all outputs 0 immediately, no out_valid pulse, len=0.

Source files
------------

// File: rtl/laser_seq_ctrl.sv
// Record/playback sequencer: captures a byte stream into an external RAM, then
// replays it at one sample every PERIOD clocks, optionally looping.
module laser_seq_ctrl #(
  parameter int unsigned AW     = 4,
  parameter int unsigned PERIOD = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rec,
  input  logic          play,
  input  logic          stop,
  input  logic          loop,
  input  logic [7:0]    in,
  input  logic          in_valid,
  output logic [7:0]    out,
  output logic          out_valid,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   len,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_wdata,
  output logic          ram_we,
  input  logic [7:0]    ram_rdata
);

  localparam int unsigned TW    = 8;
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, REC, PLAY} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] wptr, rptr;
  logic [TW-1:0] timer;
  logic          fin;
  logic          iss_q, iss_last_q, cap_q, cap_last_q;

  logic start_rec, start_play, wr_acc, wr_full;
  logic rd_issue, rd_last, rd_done, abort;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state plus one-cycle control strobes for the datapath
  always_comb begin
    state_nxt  = state;
    start_rec  = 1'b0;
    start_play = 1'b0;
    wr_acc     = 1'b0;
    wr_full    = 1'b0;
    rd_issue   = 1'b0;
    rd_last    = 1'b0;
    rd_done    = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (rec) begin
          start_rec = 1'b1;
          state_nxt = REC;
        end else if (play && len != '0) begin
          start_play = 1'b1;
          state_nxt  = PLAY;
        end
      end
      REC: begin
        if (stop) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (in_valid) begin
          wr_acc = 1'b1;
          if (len == LW'(DEPTH - 1)) begin
            wr_full   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      PLAY: begin
        if (stop) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          rd_issue = (timer == '0) && !fin;
          rd_last  = rd_issue && (LW'(rptr) == len - LW'(1));
          // Final word of a non-looping pass lands in out this cycle
          if (cap_q && cap_last_q) begin
            rd_done   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: pointers, RAM port, two-stage read pipeline and sample output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out        <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      len        <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_we     <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      timer      <= '0;
      fin        <= 1'b0;
      iss_q      <= 1'b0;
      iss_last_q <= 1'b0;
      cap_q      <= 1'b0;
      cap_last_q <= 1'b0;
    end else begin
      ram_we    <= 1'b0;
      out_valid <= 1'b0;
      done      <= wr_full | abort | rd_done;
      busy      <= (state_nxt != IDLE);
      if (start_rec) begin
        wptr <= '0;
        len  <= '0;
      end
      if (start_play) begin
        rptr       <= '0;
        timer      <= '0;
        fin        <= 1'b0;
        iss_q      <= 1'b0;
        iss_last_q <= 1'b0;
        cap_q      <= 1'b0;
        cap_last_q <= 1'b0;
      end
      if (wr_acc) begin
        ram_we    <= 1'b1;
        ram_addr  <= wptr;
        ram_wdata <= in;
        wptr      <= wptr + AW'(1);
        len       <= len + LW'(1);
      end
      if (state == PLAY && !abort) begin
        timer      <= (timer == TW'(PERIOD - 1)) ? '0 : timer + TW'(1);
        iss_q      <= rd_issue;
        iss_last_q <= rd_last && !loop;
        cap_q      <= iss_q;
        cap_last_q <= iss_last_q;
        if (cap_q) begin
          out       <= ram_rdata;
          out_valid <= 1'b1;
        end
      end
      // Abort drops any read still travelling through the pipeline
      if (abort) begin
        iss_q      <= 1'b0;
        iss_last_q <= 1'b0;
        cap_q      <= 1'b0;
        cap_last_q <= 1'b0;
      end
      if (rd_issue) begin
        ram_addr <= rptr;
        rptr     <= (rd_last && loop) ? '0 : rptr + AW'(1);
        if (rd_last && !loop) fin <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_laser_seq_ctrl.sv
// Bench for laser_seq_ctrl: behavioural RAM, recorded-sample queue and a
// cycle-timeline model of playback derived from PERIOD and the read latency.
module tb_laser_seq_ctrl;

  localparam int unsigned AW     = 4;
  localparam int unsigned PERIOD = 4;
  localparam int          DEPTH  = 1 << AW;

  typedef logic [7:0] byte_q_t[$];

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rec, play, stop, loop, in_valid;
  logic [7:0]    in;
  logic [7:0]    out;
  logic          out_valid, busy, done;
  logic [AW:0]   len;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic          ram_we;
  logic [7:0]    ram_rdata;

  logic [7:0] mem [DEPTH];

  int      total = 0;
  int      bad   = 0;
  byte_q_t mdl_q;
  byte_q_t fixed;
  logic [7:0] out_exp;

  laser_seq_ctrl #(.AW(AW), .PERIOD(PERIOD)) dut (
    .clk(clk), .reset(reset), .rec(rec), .play(play), .stop(stop), .loop(loop),
    .in(in), .in_valid(in_valid), .out(out), .out_valid(out_valid), .busy(busy),
    .done(done), .len(len), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data valid one cycle after the address is presented
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    rec = 1'b0; play = 1'b0; stop = 1'b0; loop = 1'b0; in_valid = 1'b0; in = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out"}, out, 0);
    check({tag, "_ov"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_len"}, len, 0);
    check({tag, "_addr"}, ram_addr, 0);
    check({tag, "_wdata"}, ram_wdata, 0);
    check({tag, "_we"}, ram_we, 0);
  endtask

  // Record n words (from fixed if given); stop after n, or fill to DEPTH without stop
  task automatic record_run(input byte_q_t src, input int n, input bit do_stop, input bit gappy);
    int acc; int guard; bit we_e; bit done_e;
    logic [AW-1:0] a_e; logic [7:0] d_e; logic [7:0] b;
    @(negedge clk); drive_idle(); rec = 1'b1; play = 1'b1;
    mdl_q.delete(); acc = 0; guard = 0; we_e = 1'b0; done_e = 1'b0; a_e = '0; d_e = '0;
    forever begin
      @(negedge clk); drive_idle();
      check("rec_we", ram_we, we_e);
      if (we_e) begin
        check("rec_addr", ram_addr, a_e);
        check("rec_wdata", ram_wdata, d_e);
      end
      check("rec_done", done, done_e);
      check("rec_busy", busy, !done_e);
      check("rec_len", len, acc);
      if (done_e) break;
      guard++;
      we_e = 1'b0;
      if (acc == n && do_stop) begin
        stop = 1'b1; in_valid = 1'b1; in = 8'($urandom); done_e = 1'b1;
      end else if (gappy && guard < 100 && $urandom_range(0, 2) == 0) begin
        in = 8'($urandom);
        if ($urandom_range(0, 1) == 1) begin rec = 1'b1; play = 1'b1; end
      end else begin
        b = (src.size() > 0) ? src[acc] : 8'($urandom);
        in = b; in_valid = 1'b1;
        we_e = 1'b1; a_e = AW'(acc); d_e = b;
        mdl_q.push_back(b);
        acc++;
        if (acc == DEPTH) done_e = 1'b1;
      end
    end
  endtask

  // Play back mdl_q; play pulse at t=0, address of read j at t=2+j*PERIOD,
  // sample k shown at t=4+k*PERIOD. stop_t>0 raises stop in that cycle.
  task automatic play_run(input bit lp, input int stop_t);
    int t; int k; int j; int n; bit ov_e; bit done_e;
    n = mdl_q.size();
    @(negedge clk); drive_idle(); play = 1'b1; loop = lp;
    t = 0; k = 0;
    forever begin
      @(negedge clk); drive_idle(); loop = lp; t++;
      if (stop_t != 0 && t == stop_t + 1) begin
        check("stop_done", done, 1);
        check("stop_busy", busy, 0);
        check("stop_ov", out_valid, 0);
        check("stop_out", out, out_exp);
        break;
      end
      ov_e = (t == 4 + k * PERIOD);
      check("play_ov", out_valid, ov_e);
      if (ov_e) begin
        out_exp = mdl_q[k % n];
        k++;
      end
      check("play_out", out, out_exp);
      done_e = ov_e && !lp && (k == n);
      check("play_done", done, done_e);
      check("play_busy", busy, !done_e);
      check("play_we", ram_we, 0);
      j = (t - 2) / PERIOD;
      if (t >= 2 && (t - 2) % PERIOD == 0 && (lp || j < n))
        check("play_addr", ram_addr, j % n);
      if (done_e) break;
      if (t == stop_t) stop = 1'b1;
      else if ($urandom_range(0, 7) == 0) begin rec = 1'b1; play = 1'b1; end
    end
    repeat (2 * PERIOD) begin
      @(negedge clk); drive_idle();
      check("quiet_ov", out_valid, 0);
      check("quiet_busy", busy, 0);
      check("quiet_done", done, 0);
      check("quiet_out", out, out_exp);
      check("quiet_len", len, n);
    end
  endtask

  initial begin
    drive_idle();
    out_exp = '0;
    reset = 1'b0;
    #1;
    check_all_zero("rst");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);

    // stop in IDLE and play with nothing recorded are both no-ops
    stop = 1'b1;
    @(negedge clk); drive_idle();
    check("idle_stop_busy", busy, 0);
    check("idle_stop_done", done, 0);
    play = 1'b1;
    @(negedge clk); drive_idle();
    check("empty_play_busy", busy, 0);
    check("empty_play_done", done, 0);
    check("empty_play_len", len, 0);

    // Directed record of 11,22,33 then playback without loop
    fixed.delete();
    fixed.push_back(8'h11); fixed.push_back(8'h22); fixed.push_back(8'h33);
    record_run(fixed, 3, 1'b1, 1'b0);
    play_run(1'b0, 0);

    // Fill the RAM, then one more in_valid must not write
    fixed.delete();
    record_run(fixed, DEPTH, 1'b0, 1'b1);
    in_valid = 1'b1; in = 8'h5a;
    @(negedge clk); drive_idle();
    check("full_extra_we", ram_we, 0);
    check("full_extra_len", len, DEPTH);
    check("full_extra_busy", busy, 0);
    check("full_extra_done", done, 0);
    play_run(1'b0, 0);

    // Looping playback of AA,BB stopped on the sixth sample
    fixed.delete();
    fixed.push_back(8'haa); fixed.push_back(8'hbb);
    record_run(fixed, 2, 1'b1, 1'b0);
    play_run(1'b1, 4 + 5 * PERIOD);

    // Randomised record lengths, loop modes and stop points
    fixed.delete();
    for (int r = 0; r < 8; r++) begin
      int n; bit lp; int st;
      n = $urandom_range(1, DEPTH - 1);
      record_run(fixed, n, 1'b1, 1'b1);
      lp = 1'($urandom);
      if (lp) st = $urandom_range(1, 3 * n * PERIOD + 8);
      else if ($urandom_range(0, 1) == 1) st = $urandom_range(1, 3 + (n - 1) * PERIOD);
      else st = 0;
      play_run(lp, st);
    end

    // Asynchronous reset between a read issue and its out_valid
    record_run(fixed, 3, 1'b1, 1'b0);
    @(negedge clk); drive_idle(); play = 1'b1;
    repeat (3) begin @(negedge clk); drive_idle(); end
    check("pre_rst_busy", busy, 1);
    check("pre_rst_ov", out_valid, 0);
    #2 reset = 1'b0;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    check("mid_rst_ov_hold", out_valid, 0);
    check("mid_rst_len_hold", len, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rel_busy", busy, 0);
    check("rel_ov", out_valid, 0);
    check("rel_len", len, 0);
    check("rel_done", done, 0);
    play = 1'b1;
    @(negedge clk); drive_idle();
    check("rel_play_busy", busy, 0);
    check("rel_play_done", done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
